enigma_step_ctrl: RTL and testbench

Sequencer for the Enigma rotor datapath. Accepts one letter (0..25) per transaction and applies the odometer/double-step rotor advance. It then time-multiplexes a single shared wiring-lookup unit through seven passes: rotor0/1/2 forward, reflector, rotor2/1/0 reverse. All mod-26 position offsetting lives here, so the lookup unit returns raw wiring only.

---
 rtl/enigma_step_ctrl.sv | 173 +++++++++++++++++
 tb/tb_enigma_step_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enigma_step_ctrl.sv
// Enigma rotor sequencer: odometer/double-step advance, then seven passes through a shared wiring LUT.
// Latency: acceptance at edge k -> out_valid after edge k+8 (k+2 for an out-of-range letter).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE with no cfg_load pending.
module enigma_step_ctrl #(
  parameter int NOTCH0 = 16,
  parameter int NOTCH1 = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] in_char,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] out_char,
  output logic       out_err,
  input  logic       cfg_load,
  input  logic [4:0] cfg_pos0,
  input  logic [4:0] cfg_pos1,
  input  logic [4:0] cfg_pos2,
  output logic [4:0] pos0,
  output logic [4:0] pos1,
  output logic [4:0] pos2,
  output logic [1:0] lut_sel,
  output logic       lut_rev,
  output logic [4:0] lut_in,
  input  logic [4:0] lut_out,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, STEP, PASS, DONE} state_t;

  localparam logic [4:0] N0 = 5'(NOTCH0);
  localparam logic [4:0] N1 = 5'(NOTCH1);

  state_t     state, state_nxt;
  logic [2:0] p;
  logic [4:0] cur;

  // Values presented to the lookup unit during PASS, and their held copies outside it
  logic [1:0] pass_sel;
  logic       pass_rev;
  logic [4:0] pass_off;
  logic [4:0] lut_in_c;
  logic [4:0] cur_nxt;
  logic [1:0] lut_sel_q;
  logic       lut_rev_q;
  logic [4:0] lut_in_q;

  logic       cur_bad;
  logic       carry1;
  logic       carry2;

  // Single conditional subtract: every operand pair here sums to at most 51
  function automatic logic [4:0] wrap26(input logic [5:0] v);
    wrap26 = (v >= 6'd26) ? 5'(v - 6'd26) : v[4:0];
  endfunction

  function automatic logic [4:0] inc26(input logic [4:0] v);
    inc26 = (v == 5'd25) ? 5'd0 : v + 5'd1;
  endfunction

  assign in_ready = (state == IDLE) && !cfg_load;
  assign busy     = (state != IDLE);
  assign cur_bad  = (cur > 5'd25);
  // Notch tests look at pre-step positions; carry2 is the double-step condition
  assign carry2   = (pos1 == N1);
  assign carry1   = (pos0 == N0) || carry2;

  assign lut_sel  = (state == PASS) ? pass_sel : lut_sel_q;
  assign lut_rev  = (state == PASS) ? pass_rev : lut_rev_q;
  assign lut_in   = (state == PASS) ? lut_in_c : lut_in_q;

  // Pass decode: rotors 0,1,2 forward, reflector, then rotors 2,1,0 reverse; mod-26 offsetting
  always_comb begin
    pass_sel = 2'd0;
    pass_rev = 1'b0;
    pass_off = 5'd0;
    if (p <= 3'd2) begin
      pass_sel = p[1:0];
    end else if (p == 3'd3) begin
      pass_sel = 2'd3;
    end else begin
      pass_sel = 2'(3'd6 - p);
      pass_rev = 1'b1;
    end
    case (pass_sel)
      2'd0:    pass_off = pos0;
      2'd1:    pass_off = pos1;
      2'd2:    pass_off = pos2;
      default: pass_off = 5'd0;
    endcase
    lut_in_c = wrap26({1'b0, cur} + {1'b0, pass_off});
    cur_nxt  = wrap26({1'b0, lut_out} + 6'd26 - {1'b0, pass_off});
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid && in_ready) state_nxt = STEP;
      STEP: state_nxt = cur_bad ? DONE : PASS;
      PASS: if (p == 3'd6) state_nxt = DONE;
      DONE: if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: positions, working letter, pass counter, result and LUT hold registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos0      <= 5'd0;
      pos1      <= 5'd0;
      pos2      <= 5'd0;
      cur       <= 5'd0;
      p         <= 3'd0;
      out_valid <= 1'b0;
      out_char  <= 5'd0;
      out_err   <= 1'b0;
      lut_sel_q <= 2'd0;
      lut_rev_q <= 1'b0;
      lut_in_q  <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_load) begin
            pos0 <= (cfg_pos0 > 5'd25) ? 5'd0 : cfg_pos0;
            pos1 <= (cfg_pos1 > 5'd25) ? 5'd0 : cfg_pos1;
            pos2 <= (cfg_pos2 > 5'd25) ? 5'd0 : cfg_pos2;
          end else if (in_valid) begin
            cur <= in_char;
            p   <= 3'd0;
          end
        end
        STEP: begin
          if (!cur_bad) begin
            pos0 <= inc26(pos0);
            if (carry1) pos1 <= inc26(pos1);
            if (carry2) pos2 <= inc26(pos2);
          end else begin
            // Illegal letter passes straight through, flagged; valid rises one cycle later in DONE
            out_char <= cur;
            out_err  <= 1'b1;
          end
        end
        PASS: begin
          cur       <= cur_nxt;
          p         <= p + 3'd1;
          lut_sel_q <= pass_sel;
          lut_rev_q <= pass_rev;
          lut_in_q  <= lut_in_c;
          if (p == 3'd6) begin
            out_char  <= cur_nxt;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (!out_valid)     out_valid <= 1'b1;
          else if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_step_ctrl.sv
// Bench for enigma_step_ctrl: two instances (default notches, and NOTCH0=25), each with a wiring LUT stub.
// Expected results come from a letter-level Enigma model; a forked monitor checks them on each handshake.
// Waits are bounded; the run always ends with one summary line.
module tb_enigma_step_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid_a = 1'b0, in_valid_b = 1'b0;
  logic [4:0] in_char = 5'd0;
  logic       out_ready = 1'b1;
  logic       cfg_load = 1'b0;
  logic [4:0] cfg_pos0 = 5'd0, cfg_pos1 = 5'd0, cfg_pos2 = 5'd0;

  logic       in_ready_a, out_valid_a, out_err_a, lut_rev_a, busy_a;
  logic [4:0] out_char_a, pos0_a, pos1_a, pos2_a, lut_in_a, lut_out_a;
  logic [1:0] lut_sel_a;
  logic       in_ready_b, out_valid_b, out_err_b, lut_rev_b, busy_b;
  logic [4:0] out_char_b, pos0_b, pos1_b, pos2_b, lut_in_b, lut_out_b;
  logic [1:0] lut_sel_b;

  int  fwd_t[4][26];
  int  inv_t[4][26];
  bit  use_id = 1'b1;
  bit  rand_rdy = 1'b0;

  typedef struct packed {logic err; logic [4:0] ch;} exp_t;
  exp_t qa[$];
  exp_t qb[$];
  int   got_a[$];
  int   mpos[2][3];
  int   checks = 0;
  int   failures = 0;

  enigma_step_ctrl u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_char(in_char),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_char(out_char_a), .out_err(out_err_a),
    .cfg_load(cfg_load), .cfg_pos0(cfg_pos0), .cfg_pos1(cfg_pos1), .cfg_pos2(cfg_pos2),
    .pos0(pos0_a), .pos1(pos1_a), .pos2(pos2_a), .lut_sel(lut_sel_a), .lut_rev(lut_rev_a),
    .lut_in(lut_in_a), .lut_out(lut_out_a), .busy(busy_a));

  enigma_step_ctrl #(.NOTCH0(25), .NOTCH1(4)) u_dut25 (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_char(in_char),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_char(out_char_b), .out_err(out_err_b),
    .cfg_load(cfg_load), .cfg_pos0(cfg_pos0), .cfg_pos1(cfg_pos1), .cfg_pos2(cfg_pos2),
    .pos0(pos0_b), .pos1(pos1_b), .pos2(pos2_b), .lut_sel(lut_sel_b), .lut_rev(lut_rev_b),
    .lut_in(lut_in_b), .lut_out(lut_out_b), .busy(busy_b));

  // Wiring lookup stub: identity or rotors I, II, III and reflector B
  function automatic logic [4:0] lut_f(input logic [1:0] s, input logic r, input logic [4:0] x);
    if (x > 5'd25) return 5'd0;
    if (use_id) return x;
    return 5'(r ? inv_t[s][x] : fwd_t[s][x]);
  endfunction
  assign lut_out_a = lut_f(lut_sel_a, lut_rev_a, lut_in_a);
  assign lut_out_b = lut_f(lut_sel_b, lut_rev_b, lut_in_b);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: bound expired, got no response expected one", nm);
  endtask

  // Reference model: odometer advance with double-step, then a letter walk through the machine
  function automatic void model_step(input int d);
    int  n0;
    bit  c1, c2;
    n0 = (d == 0) ? 16 : 25;
    c2 = (mpos[d][1] == 4);
    c1 = (mpos[d][0] == n0) || c2;
    mpos[d][0] = (mpos[d][0] + 1) % 26;
    if (c1) mpos[d][1] = (mpos[d][1] + 1) % 26;
    if (c2) mpos[d][2] = (mpos[d][2] + 1) % 26;
  endfunction

  function automatic int encipher(input int d, input int c, output int tr[7]);
    int so[7];
    int off, idx, w;
    so = '{0, 1, 2, 3, 2, 1, 0};
    for (int i = 0; i < 7; i++) begin
      off   = (so[i] == 3) ? 0 : mpos[d][so[i]];
      idx   = (c + off) % 26;
      tr[i] = idx;
      if (use_id)     w = idx;
      else if (i > 3) w = inv_t[so[i]][idx];
      else            w = fwd_t[so[i]][idx];
      c = (w - off + 26) % 26;
    end
    return c;
  endfunction

  function automatic logic [4:0] posv(input int d, input int i);
    if (d == 0) return (i == 0) ? pos0_a : (i == 1) ? pos1_a : pos2_a;
    return (i == 0) ? pos0_b : (i == 1) ? pos1_b : pos2_b;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while ((busy_a || busy_b) && n < 300) begin @(posedge clk); #1; n++; end
    if (n >= 300) fail_now("wait_idle");
  endtask

  task automatic do_cfg(input int a, input int b, input int c);
    wait_idle();
    cfg_pos0 = 5'(a); cfg_pos1 = 5'(b); cfg_pos2 = 5'(c);
    cfg_load = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mpos[d][0] = (a > 25) ? 0 : a;
      mpos[d][1] = (b > 25) ? 0 : b;
      mpos[d][2] = (c > 25) ? 0 : c;
    end
    for (int i = 0; i < 3; i++) chk("cfg_pos", posv(0, i), mpos[0][i]);
  endtask

  // Issue one letter; the expected result goes to the scoreboard, optional timing/LUT checks here
  task automatic send(input int d, input int ch, input bit chk_lut, input bit chk_lat, input int exp_ovr);
    int n = 0;
    int cnt = 0;
    int r;
    int tr[7];
    bit err;
    exp_t e;
    while (!(d != 0 ? in_ready_b : in_ready_a) && n < 300) begin @(posedge clk); #1; n++; end
    if (n >= 300) begin fail_now("accept"); return; end
    in_char = 5'(ch);
    if (d != 0) in_valid_b = 1'b1; else in_valid_a = 1'b1;
    @(posedge clk); #1;
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    err = (ch > 25);
    r = ch;
    if (!err) begin model_step(d); r = encipher(d, ch, tr); end
    if (exp_ovr >= 0) r = exp_ovr;
    e.err = err; e.ch = 5'(r);
    if (d != 0) qb.push_back(e); else qa.push_back(e);
    @(posedge clk); #1; cnt = 1;
    for (int i = 0; i < 3; i++) chk(d != 0 ? "pos_b" : "pos_a", posv(d, i), mpos[d][i]);
    if (chk_lut && !err) begin
      for (int i = 0; i < 7; i++) begin
        chk("lut_in", lut_in_a, tr[i]);
        chk("lut_sel", lut_sel_a, (i == 3) ? 3 : (i < 3) ? i : 6 - i);
        chk("lut_rev", lut_rev_a, (i > 3) ? 1 : 0);
        @(posedge clk); #1; cnt++;
      end
    end
    if (chk_lat) begin
      while (!(d != 0 ? out_valid_b : out_valid_a) && cnt < 40) begin @(posedge clk); #1; cnt++; end
      chk("latency", cnt, err ? 2 : 8);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 600) begin @(posedge clk); #1; n++; end
    if (n >= 600) fail_now("drain");
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_ready && out_valid_a) begin
        if (qa.size() == 0) begin
          checks++; failures++;
          $display("FAIL a_spurious: got out_valid=1 expected no pending result");
        end else begin
          e = qa.pop_front();
          chk("a_out_char", out_char_a, e.ch);
          chk("a_out_err", out_err_a, e.err);
          got_a.push_back(int'(out_char_a));
        end
      end
      if (!rst && out_ready && out_valid_b) begin
        if (qb.size() == 0) begin
          checks++; failures++;
          $display("FAIL b_spurious: got out_valid=1 expected no pending result");
        end else begin
          e = qb.pop_front();
          chk("b_out_char", out_char_b, e.ch);
          chk("b_out_err", out_err_b, e.err);
        end
      end
    end
  endtask

  task automatic rdy_drv();
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    string w[4];
    int plain[20];
    int cipher[$];
    int s0, s1, s2;
    exp_t he;
    w[0] = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    w[1] = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
    w[2] = "BDFHJLCPRTXNGOYKMQUSZAIEWV";
    w[3] = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 26; i++) begin
        fwd_t[r][i] = int'(w[r][i]) - 65;
        inv_t[r][fwd_t[r][i]] = i;
      end
    for (int d = 0; d < 2; d++) for (int i = 0; i < 3; i++) mpos[d][i] = 0;

    fork
      monitor();
      rdy_drv();
    join_none

    // Reset values
    #1 rst = 1'b1;
    #2;
    chk("rst_busy", busy_a, 0);
    chk("rst_in_ready", in_ready_a, 1);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_out_char", out_char_a, 0);
    chk("rst_out_err", out_err_a, 0);
    chk("rst_pos", {pos0_a, pos1_a, pos2_a}, 0);
    chk("rst_lut", {lut_sel_a, lut_rev_a, lut_in_a}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Identity wiring: pass-through, single step, LUT index sequence and latency
    use_id = 1'b1;
    do_cfg(0, 0, 0);
    send(0, 7, 1'b1, 1'b1, -1);
    do_cfg(16, 0, 0);
    send(0, 0, 1'b0, 1'b1, -1);
    do_cfg(17, 4, 0);
    send(0, 0, 1'b0, 1'b1, -1);
    // NOTCH0 = 25 instance: wrap carry, then a double-step
    do_cfg(25, 25, 25);
    send(1, 5, 1'b0, 1'b1, -1);
    do_cfg(25, 3, 25);
    send(1, 9, 1'b0, 1'b0, -1);
    send(1, 11, 1'b0, 1'b0, -1);
    wait_drain();

    // Real wiring: 20 letters back to back, then decipher the DUT's own ciphertext
    use_id = 1'b0;
    s0 = $urandom_range(0, 25); s1 = $urandom_range(0, 25); s2 = $urandom_range(0, 25);
    do_cfg(s0, s1, s2);
    got_a.delete();
    for (int i = 0; i < 20; i++) begin
      plain[i] = $urandom_range(0, 25);
      send(0, plain[i], 1'b0, 1'b0, -1);
    end
    wait_drain();
    cipher = got_a;
    chk("cipher_count", cipher.size(), 20);
    do_cfg(s0, s1, s2);
    for (int i = 0; i < cipher.size(); i++) send(0, cipher[i], 1'b0, 1'b0, plain[i]);
    wait_drain();

    // Out-of-range letter and out-of-range start position
    do_cfg(28, 3, 9);
    send(0, 30, 1'b0, 1'b1, -1);
    wait_drain();

    // Backpressure: result held, no acceptance, cfg_load ignored while busy
    out_ready = 1'b0;
    send(0, $urandom_range(0, 25), 1'b0, 1'b1, -1);
    he = (qa.size() != 0) ? qa[$] : '0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", out_valid_a, 1);
      chk("hold_char", out_char_a, he.ch);
      chk("hold_in_ready", in_ready_a, 0);
      cfg_pos0 = 5'd9; cfg_pos1 = 5'd9; cfg_pos2 = 5'd9;
      cfg_load = (i == 1);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) chk("hold_pos", posv(0, i), mpos[0][i]);
    out_ready = 1'b1;
    wait_drain();

    // Random letters (including illegal ones) with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 25; i++) begin
      if (i % 8 == 0) do_cfg($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      send(0, $urandom_range(0, 31), 1'b0, 1'b0, -1);
    end
    wait_drain();
    rand_rdy = 1'b0;
    out_ready = 1'b1;

    // Reset during reflector pass aborts the transaction
    do_cfg(3, 5, 7);
    in_char = 5'd12;
    in_valid_a = 1'b1;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("mid_lut_sel", lut_sel_a, 3);
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) for (int i = 0; i < 3; i++) mpos[d][i] = 0;
    chk("arst_busy", busy_a, 0);
    chk("arst_out_valid", out_valid_a, 0);
    chk("arst_out_char", out_char_a, 0);
    chk("arst_pos", {pos0_a, pos1_a, pos2_a}, 0);
    chk("arst_lut", {lut_sel_a, lut_rev_a, lut_in_a}, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    chk("abort_no_out", out_valid_a, 0);
    chk("queue_a_empty", qa.size(), 0);
    chk("queue_b_empty", qb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
